jk_excite_ctrl: RTL



---
 rtl/jk_excite_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/jk_excite_ctrl.sv
// Write-side controller for a JK flip-flop bank: encodes per-bit J/K excitation
// from the target and live Qout, drives it for one clock, verifies, and retries.
module jk_excite_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [WIDTH-1:0]           req_target,
    input  logic [WIDTH-1:0]           q_fb,
    output logic [WIDTH-1:0]           j_out,
    output logic [WIDTH-1:0]           k_out,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(WIDTH+1)-1:0] flips
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  target;
    logic [RW-1:0]     retry;

    // Bank cell: J=1,K=1 hold; J=1,K=0 set; J=0 toggle (used only to clear a 1).
    function automatic logic [WIDTH-1:0] enc_j(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] q);
        return ~(q & ~t);
    endfunction

    function automatic logic [WIDTH-1:0] enc_k(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] q);
        return ~(t & ~q);
    endfunction

    function automatic logic [FW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [FW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) cnt = cnt + FW'(v[i]);
        return cnt;
    endfunction

    // NOTE: j_out/k_out sit in the async reset branch so the bank is forced to
    // hold the instant reset_n falls, without waiting for a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            j_out     <= '1;
            k_out     <= '1;
            done      <= 1'b0;
            err       <= 1'b0;
            flips     <= '0;
            retry     <= '0;
            target    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        target    <= req_target;
                        flips     <= popcount(req_target ^ q_fb);
                        j_out     <= enc_j(req_target, q_fb);
                        k_out     <= enc_k(req_target, q_fb);
                        retry     <= '0;
                        req_ready <= 1'b0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    j_out <= '1;
                    k_out <= '1;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == target) begin
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (retry < RW'(MAX_RETRY)) begin
                        // Re-encode from live Qout so bits already correct are held, not re-toggled.
                        retry <= retry + RW'(1);
                        j_out <= enc_j(target, q_fb);
                        k_out <= enc_k(target, q_fb);
                        state <= DRIVE;
                    end else begin
                        err       <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    j_out     <= '1;
                    k_out     <= '1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
